// File: rtl/triangle_dispatch_queue.sv
// triangle_dispatch_queue: buffers assembled triangles in a small FIFO and hands them out
// round-robin to an array of rasterizers over a shared registered bus with one-hot starts.
module triangle_dispatch_queue #(
    parameter int unsigned DEPTH           = 4,
    parameter int unsigned NUM_RASTERIZERS = 2
) (
    input  logic                         i_clk,
    input  logic                         i_reset_n,
    input  logic                         i_valid,
    input  logic [127:0]                 i_v1,
    input  logic [127:0]                 i_v2,
    input  logic [127:0]                 i_v3,
    input  logic [127:0]                 i_c1,
    input  logic [127:0]                 i_c2,
    input  logic [127:0]                 i_c3,
    output logic                         o_pause,
    input  logic [NUM_RASTERIZERS-1:0]   i_raster_busy,
    output logic [NUM_RASTERIZERS-1:0]   o_raster_start,
    output logic [127:0]                 o_v1,
    output logic [127:0]                 o_v2,
    output logic [127:0]                 o_v3,
    output logic [127:0]                 o_c1,
    output logic [127:0]                 o_c2,
    output logic [127:0]                 o_c3,
    output logic [$clog2(DEPTH):0]       o_count,
    output logic                         o_idle,
    output logic [31:0]                  o_dispatched
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned RW = (NUM_RASTERIZERS > 1) ? $clog2(NUM_RASTERIZERS) : 1;
    localparam int unsigned TW = 6 * 128;

    logic [TW-1:0]              mem_q [DEPTH];
    logic [AW-1:0]              wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]              rd_ptr_q, rd_ptr_d;
    logic [AW:0]                count_q, count_d;
    logic [RW-1:0]              rr_q, rr_d;
    logic [NUM_RASTERIZERS-1:0] start_q, start_d;
    logic [TW-1:0]              bus_q, bus_d;
    logic [31:0]                dispatched_q, dispatched_d;
    // Low throughout reset, high from the first cycle after release; keeps o_idle low in reset.
    logic                       alive_q, alive_d;

    logic                       full, empty, push, pop;
    logic [TW-1:0]              in_tri;
    logic [NUM_RASTERIZERS-1:0] eligible, rot;
    logic [2*NUM_RASTERIZERS-1:0] doubled;
    logic [RW-1:0]              first;
    logic                       grant_found;
    logic [RW:0]                grant_sum;
    logic [RW-1:0]              grant;
    logic [RW:0]                grant_next;

    assign in_tri = {i_v1, i_v2, i_v3, i_c1, i_c2, i_c3};
    assign full   = (count_q == (AW+1)'(DEPTH));
    assign empty  = (count_q == '0);

    // Round-robin arbitration: rotate the eligible mask so rr sits at bit 0, pick the lowest.
    always_comb begin
        eligible    = ~i_raster_busy & ~start_q;
        doubled     = {eligible, eligible} >> rr_q;
        rot         = doubled[NUM_RASTERIZERS-1:0];
        first       = '0;
        grant_found = 1'b0;
        for (int i = 0; i < NUM_RASTERIZERS; i++) begin
            if (!grant_found && rot[i]) begin
                grant_found = 1'b1;
                first       = RW'(i);
            end
        end
        grant_sum = {1'b0, rr_q} + {1'b0, first};
        if (grant_sum >= (RW+1)'(NUM_RASTERIZERS)) begin
            grant_sum = grant_sum - (RW+1)'(NUM_RASTERIZERS);
        end
        grant      = grant_sum[RW-1:0];
        grant_next = {1'b0, grant} + (RW+1)'(1);
        if (grant_next >= (RW+1)'(NUM_RASTERIZERS)) begin
            grant_next = '0;
        end
    end

    // Next-state for FIFO pointers, occupancy, dispatch bus and counters.
    always_comb begin
        push         = i_reset_n && i_valid && !full;
        pop          = !empty && grant_found;
        wr_ptr_d     = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d     = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d      = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW+1)'(1);
        end else if (pop && !push) begin
            count_d = count_q - (AW+1)'(1);
        end
        rr_d         = pop ? grant_next[RW-1:0] : rr_q;
        start_d      = pop ? (NUM_RASTERIZERS'(1) << grant) : '0;
        bus_d        = pop ? mem_q[rd_ptr_q] : bus_q;
        dispatched_d = pop ? dispatched_q + 32'd1 : dispatched_q;
        alive_d      = 1'b1;
    end

    // Control state with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            rr_q         <= '0;
            start_q      <= '0;
            bus_q        <= '0;
            dispatched_q <= '0;
            alive_q      <= 1'b0;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            rr_q         <= rr_d;
            start_q      <= start_d;
            bus_q        <= bus_d;
            dispatched_q <= dispatched_d;
            alive_q      <= alive_d;
        end
    end

    // FIFO storage; contents are don't-care once the pointers are reset.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_tri;
        end
    end

    assign o_pause        = full;
    assign o_count        = count_q;
    assign o_raster_start = start_q;
    assign o_dispatched   = dispatched_q;
    assign {o_v1, o_v2, o_v3, o_c1, o_c2, o_c3} = bus_q;
    assign o_idle = alive_q && empty && (start_q == '0) && (i_raster_busy == '0);

endmodule

// File: tb/tb_triangle_dispatch_queue.sv
// Randomized bench for triangle_dispatch_queue against a queue-based reference model.
module tb_triangle_dispatch_queue;

    localparam int DEPTH = 4;
    localparam int NR    = 2;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           valid = 1'b0;
    logic [127:0]   v1 = '0, v2 = '0, v3 = '0, c1 = '0, c2 = '0, c3 = '0;
    logic [NR-1:0]  busy = '0;
    logic           o_pause, o_idle;
    logic [NR-1:0]  o_start;
    logic [127:0]   o_v1, o_v2, o_v3, o_c1, o_c2, o_c3;
    logic [$clog2(DEPTH):0] o_count;
    logic [31:0]    o_disp;

    always #5 clk = ~clk;

    triangle_dispatch_queue #(.DEPTH(DEPTH), .NUM_RASTERIZERS(NR)) dut (
        .i_clk(clk), .i_reset_n(rst_n), .i_valid(valid),
        .i_v1(v1), .i_v2(v2), .i_v3(v3), .i_c1(c1), .i_c2(c2), .i_c3(c3),
        .o_pause(o_pause), .i_raster_busy(busy), .o_raster_start(o_start),
        .o_v1(o_v1), .o_v2(o_v2), .o_v3(o_v3), .o_c1(o_c1), .o_c2(o_c2), .o_c3(o_c3),
        .o_count(o_count), .o_idle(o_idle), .o_dispatched(o_disp)
    );

    // Reference model state
    logic [767:0]   mq [$];
    int             m_rr;
    logic [NR-1:0]  m_start;
    logic [31:0]    m_disp;
    logic [767:0]   m_bus;
    bit             m_alive;
    bit             m_acc;

    int n_vec = 0;
    int n_err = 0;
    int dbl = 0;
    logic [NR-1:0] prev_dut_start = '0;

    // Producer and rasterizer models
    bit            have_tri = 0;
    logic [767:0]  cur_tri;
    int            made = 0;
    int            cnt [NR];
    logic [NR-1:0] prev_s = '0;

    task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [767:0] make_tri(input int tag);
        logic [767:0] t;
        for (int i = 0; i < 24; i++) t[i*32 +: 32] = $urandom;
        t[767:736] = tag;
        return t;
    endfunction

    task automatic drive_tri(input logic [767:0] t);
        {v1, v2, v3, c1, c2, c3} = t;
    endtask

    // Advance the model by one clock edge using the inputs the DUT samples at that edge.
    task automatic model_update();
        logic [767:0] in_t;
        int grant;
        int r;
        bit full;
        in_t  = {v1, v2, v3, c1, c2, c3};
        m_acc = 0;
        if (!rst_n) begin
            mq.delete();
            m_rr = 0; m_start = '0; m_disp = 0; m_bus = '0; m_alive = 0;
            return;
        end
        full  = (mq.size() == DEPTH);
        grant = -1;
        if (mq.size() > 0) begin
            for (int k = 0; k < NR; k++) begin
                r = (m_rr + k) % NR;
                if (grant < 0 && !busy[r] && !m_start[r]) grant = r;
            end
        end
        m_start = '0;
        if (grant >= 0) begin
            m_bus = mq.pop_front();
            m_start[grant] = 1'b1;
            m_rr = (grant + 1) % NR;
            m_disp++;
        end
        if (valid && !full) begin
            mq.push_back(in_t);
            m_acc = 1;
        end
        m_alive = 1;
    endtask

    task automatic check_outputs();
        logic exp_idle;
        exp_idle = m_alive && (mq.size() == 0) && (m_start == '0) && (busy == '0);
        check_val("count", o_count, mq.size());
        check_val("pause", o_pause, mq.size() == DEPTH);
        check_val("start", o_start, m_start);
        check_val("bus_v1", o_v1, m_bus[767:640]);
        check_val("bus_v2", o_v2, m_bus[639:512]);
        check_val("bus_v3", o_v3, m_bus[511:384]);
        check_val("bus_c1", o_c1, m_bus[383:256]);
        check_val("bus_c2", o_c2, m_bus[255:128]);
        check_val("bus_c3", o_c3, m_bus[127:0]);
        check_val("idle", o_idle, exp_idle);
        check_val("dispatched", o_disp, m_disp);
        if ((o_start & prev_dut_start) != '0) dbl++;
        prev_dut_start = o_start;
    endtask

    // Called at a negedge with inputs set: one clock, then compare at the next negedge.
    task automatic tick();
        @(posedge clk);
        model_update();
        @(negedge clk);
        check_outputs();
    endtask

    // Producer holds its triangle until the model reports it accepted.
    task automatic produce(input bit want);
        if (m_acc) have_tri = 0;
        if (!have_tri && want) begin
            cur_tri = make_tri(made);
            made++;
            have_tri = 1;
        end
        valid = have_tri;
        if (have_tri) drive_tri(cur_tri);
    endtask

    // Rasterizer raises busy one cycle after its start, for a random 1..3 cycles.
    task automatic rast(input logic [NR-1:0] perm);
        logic [NR-1:0] b;
        b = '0;
        for (int r = 0; r < NR; r++) begin
            if (cnt[r] > 0) cnt[r]--;
            if (prev_s[r]) cnt[r] = $urandom_range(1, 3);
            b[r] = (cnt[r] != 0);
        end
        prev_s = m_start;
        busy = b | perm;
    endtask

    task automatic clear_producer();
        have_tri = 0; valid = 0; made = 0; m_acc = 0;
    endtask

    initial begin
        logic [767:0] t;
        logic [31:0] disp_before;
        for (int r = 0; r < NR; r++) cnt[r] = 0;
        m_rr = 0; m_start = '0; m_disp = 0; m_bus = '0; m_alive = 0; m_acc = 0;

        // Reset and single-triangle latency
        @(negedge clk);
        rst_n = 0;
        repeat (3) tick();
        rst_n = 1;
        tick();
        t = make_tri(0);
        t[671:640] = 32'h3F800000;
        drive_tri(t);
        valid = 1;
        tick();
        valid = 0;
        tick();
        check_val("lat_start", o_start, 2'b01);
        check_val("lat_v1x", o_v1[31:0], 32'h3F800000);
        tick();
        check_val("lat_idle", o_idle, 1'b1);
        check_val("lat_disp", o_disp, 32'd1);

        // Backpressure: all busy, five triangles, fifth held until busy[0] drops
        clear_producer();
        busy = 2'b11;
        for (int i = 0; i < 12; i++) begin
            produce(made < 5);
            tick();
        end
        check_val("full_pause", o_pause, 1'b1);
        check_val("full_count", o_count, DEPTH);
        busy = 2'b10;
        for (int i = 0; i < 16; i++) begin
            produce(made < 5);
            tick();
        end

        // Free-running rasterizers: alternating starts
        clear_producer();
        busy = 2'b00;
        disp_before = o_disp;
        for (int i = 0; i < 10; i++) begin
            produce(made < 4);
            tick();
        end
        check_val("stream_disp", o_disp, disp_before + 32'd4);

        // Rasterizer model, busy[1] stuck high
        clear_producer();
        for (int i = 0; i < 40; i++) begin
            produce(made < 6);
            rast(2'b10);
            tick();
        end
        check_val("no_double_start", dbl, 0);

        // Reset with a full-ish FIFO and a start pending
        clear_producer();
        busy = 2'b11;
        for (int i = 0; i < 6; i++) begin
            produce(made < 3);
            tick();
        end
        busy = 2'b10;
        produce(made < 4);
        tick();
        check_val("rst_pre_start", o_start, 2'b01);
        check_val("rst_pre_count", o_count, 3);
        rst_n = 0;
        valid = 0;
        tick();
        check_val("rst_count", o_count, 0);
        check_val("rst_start", o_start, 0);
        check_val("rst_disp", o_disp, 0);
        check_val("rst_pause", o_pause, 0);
        rst_n = 1;
        clear_producer();
        busy = 2'b00;
        repeat (5) tick();
        check_val("rst_no_stale", o_disp, 0);

        // Randomized traffic with occasional resets and stuck-busy patterns
        clear_producer();
        for (int r = 0; r < NR; r++) cnt[r] = 0;
        begin
            logic [NR-1:0] perm;
            perm = '0;
            for (int i = 0; i < 1500; i++) begin
                if ($urandom_range(0, 19) == 0) perm = NR'($urandom_range(0, (1 << NR) - 1));
                rst_n = ($urandom_range(0, 199) != 0);
                produce($urandom_range(0, 2) != 0);
                rast(perm);
                tick();
            end
        end
        check_val("final_no_double_start", dbl, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
